vector_scale: RTL and testbench
===============================

Name: vector_scale

Overview:
- Inverse companion to the vector-length stage in the triangle rasterizer pixel pipeline.
- Takes a half-precision scalar s and a half-precision vector (x, y, z), and returns (s·x, s·y, s·z).
- Typical uses: rebuilding a vector from a unit direction and a length, or normalizing with a reciprocal length.
- Uses the same nd/us_rfd upstream and rdy/ds_rfd downstream handshake as the rest of the pipeline, and one shared fp_mul_micro core.

Parameters:
- ZERO_IDLE_OUT, 1, when 1 the out_x/out_y/out_z ports read 0 whenever rdy=0; when 0 they hold the last result.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- nd  input  1  new data; qualified by us_rfd
- us_rfd  output  1  upstream ready for data
- s  input  16  fp16 scale factor
- x  input  16  fp16 vector x component
- y  input  16  fp16 vector y component
- z  input  16  fp16 vector z component
- ds_rfd  input  1  downstream ready for data
- rdy  output  1  result valid
- out_x  output  16  fp16 s·x
- out_y  output  16  fp16 s·y
- out_z  output  16  fp16 s·z

Behaviour:
- Reset: state=IDLE, us_rfd=1, rdy=0, outputs 0, all capture registers 0, issue and result counters 0.
- Acceptance: on a cycle with nd=1 and us_rfd=1, s, x, y and z are registered. Inputs may change freely afterwards.
- States: IDLE, ISSX, ISSY, ISSZ, DRAIN, OUTPUT.
- IDLE -> ISSX on an accepted nd.
- ISSX: a=b-source is s and x; operation_nd pulses one cycle when operation_rfd=1; then -> ISSY.
- ISSY: same, using y; then -> ISSZ.
- ISSZ: same, using z; then -> DRAIN.
- In any ISS state, if operation_rfd=0 the state stalls and operation_nd stays low.
- Result collection: each mul rdy pulse writes the result to slot out_x, out_y or out_z by a 2-bit result counter, in issue order. Collection runs in ISS and DRAIN states, so results that arrive before issue finishes are kept.
- DRAIN -> OUTPUT when the third result is captured. This includes a third result arriving in the same cycle as the ISSZ issue completes.
- OUTPUT: rdy=1. The transfer happens on a cycle with rdy=1 and ds_rfd=1; then -> IDLE.
- Latency: 1 cycle for acceptance, plus 3 issue cycles, plus the core latency, plus 1 capture cycle. Not fixed; the bench checks rdy, not a cycle count.
- rdy is registered, not combinational on mul rdy.
- The multiplier ce is driven by ds_rfd so the core freezes under downstream backpressure. While ds_rfd=0, pending core results stay inside the core, no results are lost, and collection resumes when ds_rfd returns to 1.
- us_rfd=1 only in IDLE. nd outside IDLE is ignored with no side effect.
- rdy holds 1 and outputs stay stable until ds_rfd=1, for any duration.
- The core sclr is tied to rst. Reset in any state returns to IDLE within 1 cycle and discards in-flight results.
- Arithmetic is fp16 IEEE-754 from the core. Sign, zero, inf and NaN handling is the core's; the block performs no arithmetic of its own.
- A counter overflow guard prevents more than 3 captures per operation; extra core rdy pulses are ignored.

Optional Feature:
- Macro: VSCALE_UNITY_BYPASS_EN.
- Defined: if s equals 0x3C00 (+1.0) at acceptance, the core is not used. State goes IDLE -> OUTPUT directly, with out_x/out_y/out_z taking the captured x/y/z and rdy=1 on the cycle after acceptance. Any other s uses the normal path.
- Undefined: every s uses the multiplier path, including 1.0. The bypass compare logic is absent.

Test Plan:
- s=0x4000 (2.0), x=0x3E00 (1.5), y=0x4200 (3.0), z=0x3800 (0.5), ds_rfd=1 -> one rdy pulse with out_x=0x4200, out_y=0x4600, out_z=0x3C00; us_rfd returns to 1 the next cycle.
- s=0xC000 (-2.0), x=0x3C00, y=0x0000, z=0x4480 -> out_x=0xC000, out_y=0x8000, out_z=0xC880.
- Backpressure: ds_rfd=0 for 20 cycles after nd -> rdy holds 1 with stable outputs; with ZERO_IDLE_OUT=1 outputs are 0 before rdy; release gives exactly one transfer.
- nd pulsed in every state during an operation -> only the first is accepted; the second operation's results come from inputs captured at its own acceptance.
- rst asserted in DRAIN -> next cycle us_rfd=1, rdy=0, outputs 0; a following operation with s=0x4000, x=y=z=0x3C00 -> all outputs 0x4000.
- With VSCALE_UNITY_BYPASS_EN, s=0x3C00, x=0x1234 -> rdy on the cycle after acceptance with out_x=0x1234. Without the macro, the same stimulus gives the same values after the core latency.

Source files
------------

// File: rtl/vector_scale.sv
// rtl/vector_scale.sv - fp16 scalar-times-vector stage sharing one pipelined multiplier; optional VSCALE_UNITY_BYPASS_EN skips the core for s == +1.0

module fp_mul_micro (
    input  logic        clk,
    input  logic        sclr,
    input  logic        ce,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        operation_nd,
    output logic        operation_rfd,
    output logic [15:0] result,
    output logic        rdy
);
    logic [4:0]  ea, eb;
    logic [9:0]  fa, fb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [1:0]  cls;
    logic        v1, s1, v2;
    logic [1:0]  cls1;
    logic [6:0]  esum1;
    logic [21:0] p1;
    logic [15:0] r2;
    logic        norm, guard, sticky, rnd;
    logic [10:0] mant;
    logic [11:0] mant_r;
    logic [6:0]  e_adj;
    logic [9:0]  frac;
    logic [15:0] packed_res;

    assign ea = a[14:10];
    assign eb = b[14:10];
    assign fa = a[9:0];
    assign fb = b[9:0];
    // Subnormal operands are flushed to zero.
    assign a_zero = (ea == 5'd0);
    assign b_zero = (eb == 5'd0);
    assign a_inf  = (ea == 5'd31) && (fa == 10'd0);
    assign b_inf  = (eb == 5'd31) && (fb == 10'd0);
    assign a_nan  = (ea == 5'd31) && (fa != 10'd0);
    assign b_nan  = (eb == 5'd31) && (fb != 10'd0);

    // Operand class: 0 normal, 1 zero, 2 inf, 3 NaN
    always_comb begin
        cls = 2'd0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            cls = 2'd3;
        else if (a_inf || b_inf)
            cls = 2'd2;
        else if (a_zero || b_zero)
            cls = 2'd1;
    end

    // Stage 1: significand product and biased exponent sum
    always_ff @(posedge clk) begin
        if (sclr) begin
            v1    <= 1'b0;
            s1    <= 1'b0;
            cls1  <= 2'd0;
            esum1 <= 7'd0;
            p1    <= 22'd0;
        end else if (ce) begin
            v1    <= operation_nd;
            s1    <= a[15] ^ b[15];
            cls1  <= cls;
            esum1 <= {2'b00, ea} + {2'b00, eb};
            p1    <= {11'd0, 1'b1, fa} * {11'd0, 1'b1, fb};
        end
    end

    // Normalize, round to nearest even, pack with overflow/underflow handling
    always_comb begin
        norm   = p1[21];
        mant   = norm ? p1[21:11] : p1[20:10];
        guard  = norm ? p1[10] : p1[9];
        sticky = norm ? (|p1[9:0]) : (|p1[8:0]);
        rnd    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {11'd0, rnd};
        e_adj  = esum1 + {6'd0, norm} + {6'd0, mant_r[11]};
        frac   = mant_r[11] ? mant_r[10:1] : mant_r[9:0];
        // e_adj[4:0] + 17 equals the unbiased-back exponent e_adj - 15 modulo 32
        packed_res = {s1, e_adj[4:0] + 5'd17, frac};
        if (cls1 == 2'd3)
            packed_res = 16'h7E00;
        else if (cls1 == 2'd2 || (cls1 == 2'd0 && e_adj >= 7'd46))
            packed_res = {s1, 15'h7C00};
        else if (cls1 == 2'd1 || e_adj <= 7'd15)
            packed_res = {s1, 15'h0000};
    end

    // Stage 2: result register
    always_ff @(posedge clk) begin
        if (sclr) begin
            v2 <= 1'b0;
            r2 <= 16'd0;
        end else if (ce) begin
            v2 <= v1;
            if (v1)
                r2 <= packed_res;
        end
    end

    // A result is only handed over on a cycle the pipeline advances, so a frozen core never repeats one
    assign rdy           = v2 & ce;
    assign operation_rfd = ce;
    assign result        = r2;
endmodule

module vector_scale #(
    parameter int ZERO_IDLE_OUT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nd,
    output logic        us_rfd,
    input  logic [15:0] s,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] z,
    input  logic        ds_rfd,
    output logic        rdy,
    output logic [15:0] out_x,
    output logic [15:0] out_y,
    output logic [15:0] out_z
);
    typedef enum logic [2:0] {IDLE, ISSX, ISSY, ISSZ, DRAIN, OUTPUT} state_t;

    state_t      state, state_nxt;
    logic [15:0] s_q, x_q, y_q, z_q;
    logic [15:0] slot_x, slot_y, slot_z;
    logic [15:0] held_x, held_y, held_z;
    logic [1:0]  iss_cnt, res_cnt;
    logic        accept, collecting, capture, third_done;
    logic        mul_nd, mul_rfd, mul_rdy;
    logic [15:0] mul_b, mul_res;
`ifdef VSCALE_UNITY_BYPASS_EN
    logic        unity;
    assign unity = (s == 16'h3C00);
`endif

    assign us_rfd     = (state == IDLE);
    assign rdy        = (state == OUTPUT);
    assign accept     = nd && us_rfd;
    assign collecting = (state == ISSX) || (state == ISSY) || (state == ISSZ) || (state == DRAIN);
    // Never more than three captures per operation
    assign capture    = mul_rdy && collecting && (res_cnt != 2'd3);
    assign third_done = capture && (res_cnt == 2'd2);
    assign mul_b      = (iss_cnt == 2'd0) ? x_q : (iss_cnt == 2'd1) ? y_q : z_q;

    fp_mul_micro u_mul (
        .clk           (clk),
        .sclr          (rst),
        .ce            (ds_rfd),
        .a             (s_q),
        .b             (mul_b),
        .operation_nd  (mul_nd),
        .operation_rfd (mul_rfd),
        .result        (mul_res),
        .rdy           (mul_rdy)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and multiplier issue strobe
    always_comb begin
        state_nxt = state;
        mul_nd    = 1'b0;
        case (state)
            IDLE: begin
                if (nd) begin
`ifdef VSCALE_UNITY_BYPASS_EN
                    state_nxt = unity ? OUTPUT : ISSX;
`else
                    state_nxt = ISSX;
`endif
                end
            end
            ISSX: if (mul_rfd) begin mul_nd = 1'b1; state_nxt = ISSY; end
            ISSY: if (mul_rfd) begin mul_nd = 1'b1; state_nxt = ISSZ; end
            ISSZ: if (mul_rfd) begin mul_nd = 1'b1; state_nxt = third_done ? OUTPUT : DRAIN; end
            DRAIN:  if (third_done) state_nxt = OUTPUT;
            OUTPUT: if (ds_rfd) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture at acceptance and issue/result counters
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= 16'd0;
            x_q     <= 16'd0;
            y_q     <= 16'd0;
            z_q     <= 16'd0;
            iss_cnt <= 2'd0;
            res_cnt <= 2'd0;
        end else if (accept) begin
            s_q     <= s;
            x_q     <= x;
            y_q     <= y;
            z_q     <= z;
            iss_cnt <= 2'd0;
            res_cnt <= 2'd0;
        end else begin
            if (mul_nd)
                iss_cnt <= iss_cnt + 2'd1;
            if (capture)
                res_cnt <= res_cnt + 2'd1;
        end
    end

    // Result slots filled in issue order; bypass loads the vector directly
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_x <= 16'd0;
            slot_y <= 16'd0;
            slot_z <= 16'd0;
`ifdef VSCALE_UNITY_BYPASS_EN
        end else if (accept && unity) begin
            slot_x <= x;
            slot_y <= y;
            slot_z <= z;
`endif
        end else if (capture) begin
            case (res_cnt)
                2'd0:    slot_x <= mul_res;
                2'd1:    slot_y <= mul_res;
                default: slot_z <= mul_res;
            endcase
        end
    end

    // Last transferred result, shown while idle when ZERO_IDLE_OUT is 0
    always_ff @(posedge clk) begin
        if (rst) begin
            held_x <= 16'd0;
            held_y <= 16'd0;
            held_z <= 16'd0;
        end else if (rdy && ds_rfd) begin
            held_x <= slot_x;
            held_y <= slot_y;
            held_z <= slot_z;
        end
    end

    assign out_x = rdy ? slot_x : ((ZERO_IDLE_OUT != 0) ? 16'd0 : held_x);
    assign out_y = rdy ? slot_y : ((ZERO_IDLE_OUT != 0) ? 16'd0 : held_y);
    assign out_z = rdy ? slot_z : ((ZERO_IDLE_OUT != 0) ? 16'd0 : held_z);
endmodule

// File: tb/tb_vector_scale.sv
// tb/tb_vector_scale.sv - directed self-checking bench for vector_scale
module tb_vector_scale;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nd = 1'b0;
    logic        ds_rfd = 1'b1;
    logic [15:0] s = 16'd0, x = 16'd0, y = 16'd0, z = 16'd0;
    logic        us_rfd, rdy;
    logic [15:0] out_x, out_y, out_z;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    vector_scale #(.ZERO_IDLE_OUT(1)) dut (
        .clk(clk), .rst(rst), .nd(nd), .us_rfd(us_rfd),
        .s(s), .x(x), .y(y), .z(z),
        .ds_rfd(ds_rfd), .rdy(rdy),
        .out_x(out_x), .out_y(out_y), .out_z(out_z)
    );

    task automatic start_op(input logic [15:0] ss, input logic [15:0] xx,
                            input logic [15:0] yy, input logic [15:0] zz);
        @(negedge clk);
        nd = 1'b1; s = ss; x = xx; y = yy; z = zz;
        @(posedge clk);
        #1;
        nd = 1'b0; s = 16'hFFFF; x = 16'hFFFF; y = 16'hFFFF; z = 16'hFFFF;
    endtask

    task automatic wait_rdy(output bit found);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (rdy === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (us_rfd !== 1'b1) begin failures++; $display("FAIL reset_us_rfd got=%b exp=1", us_rfd); end
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", rdy); end
        checks++; if ({out_x, out_y, out_z} !== 48'd0) begin failures++; $display("FAIL reset_out got=%h exp=0", {out_x, out_y, out_z}); end
    endtask

    task automatic test_basic;
        bit f;
        start_op(16'h4000, 16'h3E00, 16'h4200, 16'h3800);
        wait_rdy(f);
        checks++; if (!f) begin failures++; $display("FAIL basic_rdy_timeout got=0 exp=1"); end
        checks++; if (out_x !== 16'h4200) begin failures++; $display("FAIL basic_out_x got=%h exp=4200", out_x); end
        checks++; if (out_y !== 16'h4600) begin failures++; $display("FAIL basic_out_y got=%h exp=4600", out_y); end
        checks++; if (out_z !== 16'h3C00) begin failures++; $display("FAIL basic_out_z got=%h exp=3c00", out_z); end
        @(negedge clk);
        checks++; if (rdy !== 1'b0 || us_rfd !== 1'b1) begin failures++; $display("FAIL basic_after got=rdy%b/us%b exp=rdy0/us1", rdy, us_rfd); end
    endtask

    task automatic test_negative;
        bit f;
        start_op(16'hC000, 16'h3C00, 16'h0000, 16'h4480);
        wait_rdy(f);
        checks++; if (!f) begin failures++; $display("FAIL neg_rdy_timeout got=0 exp=1"); end
        checks++; if ({out_x, out_y, out_z} !== {16'hC000, 16'h8000, 16'hC880}) begin
            failures++; $display("FAIL neg_out got=%h exp=c0008000c880", {out_x, out_y, out_z}); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        bit f, bad;
        int n;
        // Core frozen from acceptance: nothing may complete, idle outputs read 0
        start_op(16'h4000, 16'h4000, 16'h3C00, 16'hBC00);
        ds_rfd = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdy !== 1'b0 || {out_x, out_y, out_z} !== 48'd0) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL bp_frozen got=rdy%b out=%h exp=rdy0 out=0", rdy, {out_x, out_y, out_z}); end
        ds_rfd = 1'b1;
        wait_rdy(f);
        ds_rfd = 1'b0;
        checks++; if (!f) begin failures++; $display("FAIL bp_rdy_timeout got=0 exp=1"); end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdy !== 1'b1 || {out_x, out_y, out_z} !== {16'h4400, 16'h4000, 16'hC000}) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL bp_hold got=rdy%b out=%h exp=rdy1 out=44004000c000", rdy, {out_x, out_y, out_z}); end
        ds_rfd = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (rdy === 1'b1) n++;
            @(negedge clk);
        end
        checks++; if (n != 1) begin failures++; $display("FAIL bp_transfers got=%0d exp=1", n); end
    endtask

    task automatic test_nd_ignored;
        bit f;
        start_op(16'h4000, 16'h3C00, 16'h4000, 16'h3800);
        f = 1'b0;
        for (int i = 0; i < 60 && !f; i++) begin
            @(negedge clk);
            if (rdy === 1'b1) f = 1'b1;
            nd = 1'b1; s = 16'h4400; x = 16'h4400; y = 16'h4200; z = 16'hC400;
        end
        // Keep nd high while held in OUTPUT as well
        ds_rfd = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (!f) begin failures++; $display("FAIL ndign_rdy_timeout got=0 exp=1"); end
        checks++; if ({out_x, out_y, out_z} !== {16'h4000, 16'h4400, 16'h3C00}) begin
            failures++; $display("FAIL ndign_out1 got=%h exp=400044003c00", {out_x, out_y, out_z}); end
        nd = 1'b0; ds_rfd = 1'b1;
        @(negedge clk);
        checks++; if (rdy !== 1'b0 || us_rfd !== 1'b1) begin failures++; $display("FAIL ndign_after got=rdy%b/us%b exp=rdy0/us1", rdy, us_rfd); end
        start_op(16'hC000, 16'h4000, 16'h3800, 16'h0000);
        wait_rdy(f);
        checks++; if (!f || {out_x, out_y, out_z} !== {16'hC400, 16'hBC00, 16'h8000}) begin
            failures++; $display("FAIL ndign_out2 got=%h exp=c400bc008000", {out_x, out_y, out_z}); end
        @(negedge clk);
    endtask

    task automatic test_reset_drain;
        bit f, bad;
        start_op(16'h4200, 16'h4000, 16'h4000, 16'h4000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (us_rfd !== 1'b1 || rdy !== 1'b0 || {out_x, out_y, out_z} !== 48'd0) begin
            failures++; $display("FAIL rstdrain_state got=us%b rdy%b out=%h exp=us1 rdy0 out=0", us_rfd, rdy, {out_x, out_y, out_z}); end
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rdy !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL rstdrain_stale got=1 exp=0"); end
        start_op(16'h4000, 16'h3C00, 16'h3C00, 16'h3C00);
        wait_rdy(f);
        checks++; if (!f || {out_x, out_y, out_z} !== {16'h4000, 16'h4000, 16'h4000}) begin
            failures++; $display("FAIL rstdrain_out got=%h exp=400040004000", {out_x, out_y, out_z}); end
        @(negedge clk);
    endtask

    task automatic test_unity;
        bit f;
        start_op(16'h3C00, 16'h1234, 16'h3C00, 16'hC000);
        @(negedge clk);
`ifdef VSCALE_UNITY_BYPASS_EN
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL unity_bypass_rdy got=%b exp=1", rdy); end
        f = rdy;
`else
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL unity_core_rdy got=%b exp=0", rdy); end
        wait_rdy(f);
`endif
        checks++; if (!f || {out_x, out_y, out_z} !== {16'h1234, 16'h3C00, 16'hC000}) begin
            failures++; $display("FAIL unity_out got=%h exp=12343c00c000", {out_x, out_y, out_z}); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_backpressure();
        test_nd_ignored();
        test_reset_drain();
        test_unity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
